// File: rtl/id_pipe_ctrl_pkg.sv
// id_pipe_ctrl_pkg: shared widths and ID-stage state encodings.
//   FS_BUS_WD  - IF->ID payload width (PC + instruction)
//   ds_state_e - ID register occupancy state (EMPTY/RUN/STALL)
package id_pipe_ctrl_pkg;

    localparam int FS_BUS_WD = 64;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } ds_state_e;

endpackage

// File: rtl/id_pipe_ctrl_if.sv
// id_pipe_ctrl_if: IF->ID->EXE handshake bundle around the ID register.
//   fs_to_ds_valid/fs_to_ds_bus : IF offers an instruction
//   ds_allowin                  : ID can accept this cycle
//   ds_ready_go                 : stall unit result (0 = load-use hold)
//   es_allowin                  : EXE back-pressure
//   br_flush                    : branch redirect, kill ID contents
//   ds_valid/ds_bus             : ID register contents
//   ds_to_es_valid              : ID hands off to EXE this cycle
// slave = the ID controller, master = the surrounding pipeline.
interface id_pipe_ctrl_if
    import id_pipe_ctrl_pkg::*;
#(
    parameter int BUS_WD = FS_BUS_WD
);
    logic              fs_to_ds_valid;
    logic [BUS_WD-1:0] fs_to_ds_bus;
    logic              ds_allowin;
    logic              ds_ready_go;
    logic              es_allowin;
    logic              br_flush;
    logic              ds_valid;
    logic [BUS_WD-1:0] ds_bus;
    logic              ds_to_es_valid;

    modport slave (
        input  fs_to_ds_valid, fs_to_ds_bus, ds_ready_go, es_allowin, br_flush,
        output ds_allowin, ds_valid, ds_bus, ds_to_es_valid
    );

    modport master (
        output fs_to_ds_valid, fs_to_ds_bus, ds_ready_go, es_allowin, br_flush,
        input  ds_allowin, ds_valid, ds_bus, ds_to_es_valid
    );
endinterface

// File: rtl/id_pipe_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk, reset : clock, synchronous active-high reset
//   inc_i      : count this cycle
//   clr_i      : clear at next edge (wins over inc_i)
//   cnt_o      : current count
module sat_counter #(
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [WD-1:0] cnt_o
);
    logic [WD-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/id_pipe_ctrl.sv
// id_pipe_ctrl: decode-stage pipeline register and handshake controller.
//   clk, reset      : clock, synchronous active-high reset
//   ds_if (slave)   : IF->ID->EXE handshake and ID register contents
//   cnt_clr_i       : synchronous clear of both performance counters
//   stall_cnt_o     : cycles spent in STALL (saturating)
//   bubble_cnt_o    : cycles EXE could accept but got nothing (saturating)
//   stall_timeout_o : consecutive STALL run has reached STALL_MAX
//   state_o         : EMPTY/RUN/STALL view of the ID register
module id_pipe_ctrl
    import id_pipe_ctrl_pkg::*;
#(
    parameter int FS_BUS_WD = id_pipe_ctrl_pkg::FS_BUS_WD,
    parameter int CNT_WD    = 32,
    parameter int STALL_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    id_pipe_ctrl_if.slave     ds_if,
    input  logic              cnt_clr_i,
    output logic [CNT_WD-1:0] stall_cnt_o,
    output logic [CNT_WD-1:0] bubble_cnt_o,
    output logic              stall_timeout_o,
    output ds_state_e         state_o
);
    localparam int CW = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] CONS_MAX = CW'(STALL_MAX);

    logic                 ds_valid_q, ds_valid_d;
    logic [FS_BUS_WD-1:0] ds_bus_q, ds_bus_d;
    ds_state_e            state_q, state_d;
    logic [CW-1:0]        cons_q, cons_d;
    logic                 timeout_q;

    logic allowin, to_es, xfer_in;

    assign allowin = ~ds_valid_q | (ds_if.ds_ready_go & ds_if.es_allowin) | ds_if.br_flush;
    assign to_es   = ds_valid_q & ds_if.ds_ready_go & ~ds_if.br_flush;
    // A payload arriving under flush is wrong-path and never captured.
    assign xfer_in = allowin & ds_if.fs_to_ds_valid & ~ds_if.br_flush;

    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_bus_d   = ds_bus_q;
        if (ds_if.br_flush) begin
            ds_valid_d = 1'b0;
        end else if (xfer_in) begin
            ds_valid_d = 1'b1;
            ds_bus_d   = ds_if.fs_to_ds_bus;
        end else if (allowin) begin
            ds_valid_d = 1'b0;
        end
    end

    always_comb begin
        if (ds_if.br_flush || !ds_valid_d) begin
            state_d = ST_EMPTY;
        end else if (ds_valid_q && !ds_if.ds_ready_go) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    // cons_q is the length of the current STALL run including this cycle,
    // so stall_timeout lines up with the cycle the run reaches STALL_MAX.
    always_comb begin
        if (state_d != ST_STALL) begin
            cons_d = '0;
        end else if (cons_q == CONS_MAX) begin
            cons_d = cons_q;
        end else begin
            cons_d = cons_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            ds_bus_q   <= '0;
            state_q    <= ST_EMPTY;
            cons_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_bus_q   <= ds_bus_d;
            state_q    <= state_d;
            cons_q     <= cons_d;
            timeout_q  <= (cons_d == CONS_MAX);
        end
    end

    sat_counter #(.WD(CNT_WD)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (state_q == ST_STALL),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.WD(CNT_WD)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (ds_if.es_allowin & ~to_es),
        .clr_i (cnt_clr_i),
        .cnt_o (bubble_cnt_o)
    );

    assign ds_if.ds_allowin     = allowin;
    assign ds_if.ds_valid       = ds_valid_q;
    assign ds_if.ds_bus         = ds_bus_q;
    assign ds_if.ds_to_es_valid = to_es;
    assign stall_timeout_o      = timeout_q;
    assign state_o              = state_q;
endmodule

// File: tb/tb_id_pipe_ctrl.sv
module tb_id_pipe_ctrl;
    import id_pipe_ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cnt_clr;
    logic [CW-1:0] stall_cnt, bubble_cnt;
    logic          stall_timeout;
    ds_state_e     state;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    logic [63:0] junk;

    always #5 clk = ~clk;

    id_pipe_ctrl_if #(.BUS_WD(64)) dif ();

    id_pipe_ctrl #(.FS_BUS_WD(64), .CNT_WD(CW), .STALL_MAX(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .ds_if           (dif),
        .cnt_clr_i       (cnt_clr),
        .stall_cnt_o     (stall_cnt),
        .bubble_cnt_o    (bubble_cnt),
        .stall_timeout_o (stall_timeout),
        .state_o         (state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Settle, score any handoff to EXE, then advance one edge.
    task automatic tick();
        #1;
        if (!reset && dif.ds_to_es_valid && dif.es_allowin) begin
            if (exp_q.size() == 0) chk("handoff_unexpected", dif.ds_bus, 64'hx);
            else chk("handoff_bus", dif.ds_bus, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [63:0] fb, input logic rg,
                         input logic es, input logic fl);
        dif.fs_to_ds_valid = fv;
        dif.fs_to_ds_bus   = fb;
        dif.ds_ready_go    = rg;
        dif.es_allowin     = es;
        dif.br_flush       = fl;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cnt_clr = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("rst_valid", dif.ds_valid, 0);
        chk("rst_bus", dif.ds_bus, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);
        chk("rst_timeout", stall_timeout, 0);
        chk("rst_state", state, ST_EMPTY);
        reset = 1'b0;

        // Basic transfer in and handoff
        drive(1'b1, 64'h1C000000_02800421, 1'b1, 1'b1, 1'b0);
        chk("p1_allowin_empty", dif.ds_allowin, 1);
        exp_q.push_back(64'h1C000000_02800421);
        tick();
        chk("p1_valid", dif.ds_valid, 1);
        chk("p1_bus", dif.ds_bus, 64'h1C000000_02800421);
        chk("p1_state", state, ST_RUN);
        drive(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        chk("p1_to_es", dif.ds_to_es_valid, 1);
        tick();
        chk("p1_drain_valid", dif.ds_valid, 0);
        chk("p1_drain_state", state, ST_EMPTY);
        chk("p1_bubble", bubble_cnt, 1);

        // Three-cycle load-use stall
        drive(1'b1, 64'h1C000004_00000001, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(64'h1C000004_00000001);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'hDEAD0000_BEEF0000, 1'b0, 1'b1, 1'b0);
            chk("p2_allowin_stall", dif.ds_allowin, 0);
            chk("p2_to_es_stall", dif.ds_to_es_valid, 0);
            tick();
            chk("p2_bus_frozen", dif.ds_bus, 64'h1C000004_00000001);
            chk("p2_state_stall", state, ST_STALL);
        end
        drive(1'b1, 64'h1C000008_00000002, 1'b1, 1'b1, 1'b0);
        chk("p2_to_es_rise", dif.ds_to_es_valid, 1);
        exp_q.push_back(64'h1C000008_00000002);
        tick();
        chk("p2_stall_cnt", stall_cnt, 3);
        chk("p2_bus_next", dif.ds_bus, 64'h1C000008_00000002);
        chk("p2_state_run", state, ST_RUN);
        chk("p2_bubble", bubble_cnt, 5);
        drive(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("p2_clr_stall", stall_cnt, 0);
        chk("p2_clr_bubble", bubble_cnt, 0);

        // Stall watchdog, ten stalled cycles
        drive(1'b1, 64'h1C00000C_00000003, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(64'h1C00000C_00000003);
        tick();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
            tick();
            chk($sformatf("p3_timeout_%0d", i), stall_timeout, (i >= 8) ? 1 : 0);
        end
        drive(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("p3_timeout_clear", stall_timeout, 0);
        chk("p3_state", state, ST_EMPTY);
        chk("p3_stall_cnt", stall_cnt, 10);
        chk("p3_bubble", bubble_cnt, 11);

        // Branch flush while stalled, with a same-cycle fetch
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        drive(1'b1, 64'h1C000010_00000004, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(64'h1C000010_00000004);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'h1C000020_00000005, 1'b0, 1'b1, 1'b1);
        chk("p4_to_es_flush", dif.ds_to_es_valid, 0);
        chk("p4_allowin_flush", dif.ds_allowin, 1);
        junk = exp_q.pop_front();
        tick();
        chk("p4_valid", dif.ds_valid, 0);
        chk("p4_state", state, ST_EMPTY);
        chk("p4_bus_not_captured", dif.ds_bus, 64'h1C000010_00000004);
        chk("p4_timeout", stall_timeout, 0);

        // EXE back-pressure, then empty-ID bubbles
        drive(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        drive(1'b1, 64'h1C000030_00000006, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(64'h1C000030_00000006);
        tick();
        chk("p5_bubble_load", bubble_cnt, 1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h1C000040_00000007, 1'b1, 1'b0, 1'b0);
            chk("p5_allowin_bp", dif.ds_allowin, 0);
            tick();
            chk("p5_bus_hold", dif.ds_bus, 64'h1C000030_00000006);
            chk("p5_bubble_hold", bubble_cnt, 1);
        end
        drive(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("p5_bubble_drain", bubble_cnt, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("p5_bubble_empty_%0d", i), bubble_cnt, i);
        end

        // Counter saturation, clear, reset mid-stall
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        drive(1'b1, 64'h1C000050_00000008, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(64'h1C000050_00000008);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i >= 17) chk($sformatf("p6_sat_%0d", i), stall_cnt, 15);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("p6_clr", stall_cnt, 0);
        tick();
        chk("p6_recount", stall_cnt, 1);
        reset = 1'b1;
        drive(1'b1, 64'hFFFF0000_FFFF0000, 1'b0, 1'b1, 1'b0);
        tick();
        exp_q.delete();
        chk("p6_rst_valid", dif.ds_valid, 0);
        chk("p6_rst_bus", dif.ds_bus, 0);
        chk("p6_rst_state", state, ST_EMPTY);
        chk("p6_rst_stall", stall_cnt, 0);
        chk("p6_rst_bubble", bubble_cnt, 0);
        chk("p6_rst_timeout", stall_timeout, 0);
        reset = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("p6_after_rst_state", state, ST_EMPTY);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
